host_link_ctrl: RTL and testbench

//   Host-side sequencer between the UART byte interface and the conv2d core. Receives a framed

---
 rtl/host_link_ctrl.sv | 76 +++++++
 tb/tb_host_link_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/host_link_ctrl.sv
// host_link_ctrl: UART frame loader into the fmap bank, conv2d start/done handshake, ASCII label reply
module host_link_ctrl #(
  parameter int          FMAP_BYTES  = 784,
  parameter int          ADDR_W      = 15,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rdata,
  input  logic              rdata_valid,
  output logic [7:0]        tdata,
  output logic              tdata_req,
  input  logic              tdata_ready,
  output logic [ADDR_W-1:0] fbank_waddr,
  output logic [7:0]        fdata_w,
  output logic              fbank_wen,
  output logic              init,
  input  logic              done,
  input  logic [3:0]        label,
  output logic              busy,
  output logic              err_timeout
);
  localparam int CW = $clog2(FMAP_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, TX_LBL, TX_NL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0] lbl;
  logic accept, last, tmo;
  assign busy = state != IDLE;
  assign tdata_req = state == TX_LBL || state == TX_NL;
  assign accept = tdata_req && tdata_ready;
  assign last = cnt == CW'(FMAP_BYTES - 1);
  assign tmo = state == LOAD && !rdata_valid && tcnt == TW'(TIMEOUT_CYC - 1);
  assign err_timeout = tmo;
  // ASCII hex digit: 'A'..'F' is 8'h37 + label for label >= 10
  assign tdata = state == TX_LBL ? (lbl < 4'd10 ? 8'h30 + {4'h0, lbl} : 8'h37 + {4'h0, lbl})
               : state == TX_NL  ? 8'h0A : 8'h00;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rdata_valid && rdata == HDR_BYTE) state_n = LOAD;
      LOAD:    if (rdata_valid && last) state_n = START; else if (tmo) state_n = IDLE;
      START:   state_n = RUN;
      RUN:     if (done) state_n = TX_LBL;
      TX_LBL:  if (accept) state_n = TX_NL;
      TX_NL:   if (accept) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      lbl         <= '0;
      fbank_wen   <= 1'b0;
      fbank_waddr <= '0;
      fdata_w     <= '0;
      init        <= 1'b0;
    end else begin
      state     <= state_n;
      fbank_wen <= state == LOAD && rdata_valid;
      if (state == LOAD && rdata_valid) begin
        fbank_waddr <= ADDR_W'(cnt);
        fdata_w     <= rdata;
      end
      cnt  <= state == LOAD ? (rdata_valid ? cnt + 1'b1 : cnt) : '0;
      tcnt <= state == LOAD && !rdata_valid ? tcnt + 1'b1 : '0;
      init <= state == START;
      if (state == RUN && done) lbl <= label;
    end
  end
endmodule

// File: tb/tb_host_link_ctrl.sv
// tb_host_link_ctrl: randomized frames against a queue-based transaction model of the host link
module tb_host_link_ctrl;
  localparam int FB = 784, AW = 15, TO = 100;
  logic clk = 0, rst = 1, rdata_valid = 0, tdata_ready = 0, done = 0;
  logic [7:0] rdata = 0;
  logic [3:0] label = 0;
  logic [7:0] tdata;
  logic tdata_req, fbank_wen, init, busy, err_timeout;
  logic [AW-1:0] fbank_waddr;
  logic [7:0] fdata_w;

  host_link_ctrl #(.FMAP_BYTES(FB), .ADDR_W(AW), .HDR_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rdata(rdata), .rdata_valid(rdata_valid), .tdata(tdata),
    .tdata_req(tdata_req), .tdata_ready(tdata_ready), .fbank_waddr(fbank_waddr),
    .fdata_w(fdata_w), .fbank_wen(fbank_wen), .init(init), .done(done), .label(label),
    .busy(busy), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  int cyc = 0, errs = 0, checks = 0;
  int init_cnt, init_cyc, err_cnt, err_cyc, last_wen_cyc, last_strobe;
  logic [AW+7:0] wq[$];
  logic [7:0] txq[$];
  int txc[$];
  logic [7:0] pl[$];

  always @(posedge clk) cyc <= cyc + 1;

  // observed transactions, sampled mid-cycle
  always @(negedge clk) begin
    if (fbank_wen) begin wq.push_back({fbank_waddr, fdata_w}); last_wen_cyc = cyc; end
    if (init) begin init_cnt++; init_cyc = cyc; end
    if (tdata_req && tdata_ready) begin txq.push_back(tdata); txc.push_back(cyc); end
    if (err_timeout) begin err_cnt++; err_cyc = cyc; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic clear();
    wq.delete(); txq.delete(); txc.delete();
    init_cnt = 0; err_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rdata = b; rdata_valid = 1;
    @(negedge clk); last_strobe = cyc;
    @(posedge clk); #1 rdata_valid = 0; rdata = $urandom;
  endtask

  task automatic send_frame();
    send_byte(8'hA5);
    foreach (pl[i]) begin idle($urandom_range(0, 2)); send_byte(pl[i]); end
  endtask

  task automatic rand_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic wait_init();
    for (int k = 0; k < 20 && init_cnt == 0; k++) idle(1);
    idle(2);
  endtask

  task automatic test_reset();
    logic [35:0] outs;
    rst = 1; idle(3);
    outs = {tdata, tdata_req, fbank_waddr, fdata_w, fbank_wen, init, busy, err_timeout};
    checks++; if (outs !== 36'd0) begin errs++; $display("FAIL reset_outs: got %h expected 0", outs); end
    rst = 0; idle(1);
    rand_payload(5); send_frame();
    rst = 1; idle(3);
    outs = {tdata, tdata_req, fbank_waddr, fdata_w, fbank_wen, init, busy, err_timeout};
    checks++; if (outs !== 36'd0) begin errs++; $display("FAIL midload_reset_outs: got %h expected 0", outs); end
    rst = 0; idle(1); clear();
    send_byte(8'h12); idle(5);
    checks++; if (wq.size() != 0 || busy !== 0) begin errs++; $display("FAIL no_header: got writes=%0d busy=%b expected 0 0", wq.size(), busy); end
  endtask

  task automatic test_full_frame();
    int bad = -1;
    clear(); pl.delete();
    for (int i = 0; i < FB; i++) pl.push_back(8'(i));
    send_frame(); wait_init();
    checks++; if (wq.size() != FB) begin errs++; $display("FAIL wr_count: got %0d expected %0d", wq.size(), FB); end
    for (int i = 0; i < FB && i < wq.size() && bad < 0; i++) if (wq[i] !== {AW'(i), pl[i]}) bad = i;
    checks++; if (bad >= 0) begin errs++; $display("FAIL wr_data: idx %0d got %h expected %h", bad, wq[bad], {AW'(bad), pl[bad]}); end
    checks++; if (init_cnt != 1) begin errs++; $display("FAIL init_count: got %0d expected 1", init_cnt); end
    checks++; if (init_cyc != last_wen_cyc + 1) begin errs++; $display("FAIL init_timing: got cyc %0d expected %0d", init_cyc, last_wen_cyc + 1); end
    checks++; if (busy !== 1) begin errs++; $display("FAIL run_busy: got %b expected 1", busy); end
  endtask

  task automatic run_frame();
    clear(); rand_payload(FB); send_frame(); wait_init();
    checks++; if (init_cnt != 1 || wq.size() != FB) begin errs++; $display("FAIL frame: got init=%0d writes=%0d expected 1 %0d", init_cnt, wq.size(), FB); end
  endtask

  task automatic test_result(input logic [3:0] l, input int hold);
    string hx = "0123456789ABCDEF";
    logic [7:0] ex = hx[l];
    int bad = 0;
    clear();
    tdata_ready = (hold == 0);
    done = 1; label = l; idle(1); done = 0; label = 4'($urandom);
    repeat (hold) begin if (tdata_req !== 1 || tdata !== ex) bad++; idle(1); end
    if (hold > 0) begin
      checks++; if (bad != 0 || txq.size() != 0) begin errs++; $display("FAIL tx_hold: got %0d unstable cycles, %0d sent, expected 0 0", bad, txq.size()); end
    end
    tdata_ready = 1;
    for (int k = 0; k < 10 && txq.size() < 2; k++) idle(1);
    tdata_ready = 0;
    checks++; if (txq.size() != 2) begin errs++; $display("FAIL tx_count: got %0d expected 2", txq.size()); end
    else begin
      checks++; if (txq[0] !== ex) begin errs++; $display("FAIL tx_label: got %h expected %h", txq[0], ex); end
      checks++; if (txq[1] !== 8'h0A) begin errs++; $display("FAIL tx_nl: got %h expected 0a", txq[1]); end
      if (hold == 0) begin
        checks++; if (txc[1] != txc[0] + 1) begin errs++; $display("FAIL tx_b2b: got gap %0d expected 1", txc[1] - txc[0]); end
      end
    end
    checks++; if (busy !== 0 || tdata_req !== 0) begin errs++; $display("FAIL tx_end: got busy=%b req=%b expected 0 0", busy, tdata_req); end
  endtask

  task automatic test_ignore();
    clear();
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    idle(5);
    checks++; if (wq.size() != 0 || txq.size() != 0 || init_cnt != 0 || busy !== 1) begin
      errs++; $display("FAIL run_ignore: got wr=%0d tx=%0d init=%0d busy=%b expected 0 0 0 1", wq.size(), txq.size(), init_cnt, busy); end
    test_result(4'($urandom), $urandom_range(1, 3));
    clear(); tdata_ready = 1;
    done = 1; label = 4'($urandom); idle(1); done = 0; idle(10);
    tdata_ready = 0;
    checks++; if (txq.size() != 0 || init_cnt != 0 || busy !== 0) begin
      errs++; $display("FAIL idle_done: got tx=%0d init=%0d busy=%b expected 0 0 0", txq.size(), init_cnt, busy); end
  endtask

  task automatic test_timeout();
    clear(); rand_payload(10); send_frame();
    for (int k = 0; k < 200 && err_cnt == 0; k++) idle(1);
    idle(3);
    checks++; if (err_cnt != 1) begin errs++; $display("FAIL tmo_count: got %0d expected 1", err_cnt); end
    checks++; if (err_cyc - last_strobe != TO) begin errs++; $display("FAIL tmo_timing: got %0d expected %0d", err_cyc - last_strobe, TO); end
    checks++; if (busy !== 0 || wq.size() != 10) begin errs++; $display("FAIL tmo_state: got busy=%b wr=%0d expected 0 10", busy, wq.size()); end
    clear(); pl.delete(); pl.push_back(8'hA5); pl.push_back(8'h33); send_frame();
    for (int k = 0; k < 200 && err_cnt == 0; k++) idle(1);
    checks++; if (wq.size() != 2) begin errs++; $display("FAIL restart_count: got %0d expected 2", wq.size()); end
    else begin
      checks++; if (wq[0] !== {AW'(0), 8'hA5}) begin errs++; $display("FAIL restart_hdr_data: got %h expected %h", wq[0], {AW'(0), 8'hA5}); end
      checks++; if (wq[1] !== {AW'(1), 8'h33}) begin errs++; $display("FAIL restart_b1: got %h expected %h", wq[1], {AW'(1), 8'h33}); end
    end
    checks++; if (err_cnt != 1) begin errs++; $display("FAIL restart_tmo: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_reset_run();
    run_frame();
    rst = 1; idle(2); rst = 0; clear();
    tdata_ready = 1;
    done = 1; label = 4'd5; idle(1); done = 0; idle(10);
    tdata_ready = 0;
    checks++; if (txq.size() != 0 || busy !== 0 || init_cnt != 0) begin
      errs++; $display("FAIL reset_run: got tx=%0d busy=%b init=%0d expected 0 0 0", txq.size(), busy, init_cnt); end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_frame();
    test_result(4'd7, 5);
    run_frame();
    test_result(4'd11, 0);
    run_frame();
    test_ignore();
    test_timeout();
    test_reset_run();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
